// File: rtl/clk_en_nco_pkg.sv
// clk_en_pkg: shared widths, config request type and increment helper for clk_en_nco.
package clk_en_pkg;
   localparam int CH_IDX_W = 4;
   localparam int MAX_ACC_W = 64;

   typedef struct packed {
      logic [CH_IDX_W-1:0]  ch;
      logic [MAX_ACC_W-1:0] inc;
   } cfg_req_t;

   // f_en = f_ref * inc / 2^acc_w, so inc = f_out * 2^acc_w / f_ref (truncated)
   function automatic longint unsigned inc_from_hz(longint unsigned f_ref, longint unsigned f_out,
                                                   int unsigned acc_w);
      return (f_out << acc_w) / f_ref;
   endfunction
endpackage

// File: rtl/clk_en_nco_if.sv
// clk_en_nco_if: valid/ready configuration port of clk_en_nco.
interface clk_en_nco_if
   import clk_en_pkg::*;
#(
   parameter int ACC_W = 32
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CH_IDX_W-1:0] cfg_ch;
   logic [ACC_W-1:0]    cfg_inc;
   logic                cfg_err;

   modport master(output cfg_valid, cfg_ch, cfg_inc, input cfg_ready, cfg_err);
   modport slave(input cfg_valid, cfg_ch, cfg_inc, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_en_nco_ch.sv
// clk_en_nco_ch: one phase accumulator producing a registered carry pulse and optional toggle output.
// Square output flop exists only when CLKEN_SQ_OUT_EN is defined.
module clk_en_nco_ch #(
   parameter int               ACC_W   = 32,
   parameter logic [ACC_W-1:0] DEF_INC = '0
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             apply_now,
   input  logic [ACC_W-1:0] new_inc,
   output logic             carry,
   output logic             idle,
   output logic             en,
   output logic             sq
);
   logic [ACC_W-1:0] acc, inc, sum;

   assign {carry, sum} = {1'b0, acc} + {1'b0, inc};
   assign idle = inc == '0;

   // the wrap cycle still adds the old increment; the new one takes effect after it
   always_ff @(posedge refclk)
      if (rst) begin
         acc <= '0;
         inc <= DEF_INC;
         en  <= 1'b0;
      end else begin
         acc <= sum;
         en  <= carry;
         if (apply_now) inc <= new_inc;
      end

`ifdef CLKEN_SQ_OUT_EN
   always_ff @(posedge refclk) sq <= rst ? 1'b0 : sq ^ carry;
`else
   assign sq = 1'b0;
`endif
endmodule

// File: rtl/clk_en_nco.sv
// clk_en_nco: N-channel NCO clock-enable generator with glitch-free runtime reprogramming.
// Define CLKEN_SQ_OUT_EN to enable the per-channel square outputs.
module clk_en_nco
   import clk_en_pkg::*;
#(
   parameter int                      NUM_CH      = 7,
   parameter int                      ACC_W       = 32,
   parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = '0,
   parameter int                      LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst,
   clk_en_nco_if.slave       cfg,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] clk_sq,
   output logic              locked
);
   localparam int LW = $clog2(LOCK_CYCLES + 1);

   logic                pending, pend_next, accept, in_range, apply;
   logic [CH_IDX_W-1:0] pend_ch;
   logic [ACC_W-1:0]    pend_inc;
   logic [LW-1:0]       lock_cnt;
   logic [NUM_CH-1:0]   apply_v, carry_v, idle_v;

   assign accept    = cfg.cfg_valid & cfg.cfg_ready;
   assign in_range  = {1'b0, cfg.cfg_ch} < (CH_IDX_W + 1)'(NUM_CH);
   assign apply     = |apply_v;
   assign pend_next = (accept & in_range) | (pending & !apply);
   assign locked    = !pending && lock_cnt == LW'(LOCK_CYCLES);

   always_ff @(posedge refclk)
      if (rst) begin
         pending       <= 1'b0;
         pend_ch       <= '0;
         pend_inc      <= '0;
         cfg.cfg_ready <= 1'b0;
         cfg.cfg_err   <= 1'b0;
         lock_cnt      <= '0;
      end else begin
         pending       <= pend_next;
         cfg.cfg_ready <= !pend_next;
         cfg.cfg_err   <= accept & !in_range;
         if (accept & in_range) begin
            pend_ch  <= cfg.cfg_ch;
            pend_inc <= cfg.cfg_inc;
         end
         lock_cnt <= apply ? '0 : lock_cnt + LW'(lock_cnt != LW'(LOCK_CYCLES));
      end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // an idle channel never wraps, so it takes the new increment straight away
      assign apply_v[i] = pending & (pend_ch == CH_IDX_W'(i)) & (idle_v[i] | carry_v[i]);
      clk_en_nco_ch #(
         .ACC_W  (ACC_W),
         .DEF_INC(DEFAULT_INC[i*ACC_W+:ACC_W])
      ) u_ch (
         .refclk   (refclk),
         .rst      (rst),
         .apply_now(apply_v[i]),
         .new_inc  (pend_inc),
         .carry    (carry_v[i]),
         .idle     (idle_v[i]),
         .en       (clk_en[i]),
         .sq       (clk_sq[i])
      );
   end
endmodule

// File: tb/tb_clk_en_nco.sv
// tb_clk_en_nco: directed checks of clk_en_nco with NUM_CH=2, ACC_W=8, LOCK_CYCLES=4.
module tb_clk_en_nco;
   import clk_en_pkg::*;

`ifdef CLKEN_SQ_OUT_EN
   localparam bit SQ = 1'b1;
`else
   localparam bit SQ = 1'b0;
`endif

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] clk_en, clk_sq;
   logic       locked;
   int         total = 0, bad = 0, cyc = 0;

   clk_en_nco_if #(.ACC_W(8)) cfg ();

   clk_en_nco #(
      .NUM_CH     (2),
      .ACC_W      (8),
      .DEFAULT_INC(16'h0040),
      .LOCK_CYCLES(4)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .cfg   (cfg.slave),
      .clk_en(clk_en),
      .clk_sq(clk_sq),
      .locked(locked)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic drive(input logic v, input logic [3:0] ch, input logic [7:0] inc);
      cfg.cfg_valid = v;
      cfg.cfg_ch    = ch;
      cfg.cfg_inc   = inc;
   endtask

   initial begin
      drive(1'b0, 4'd0, 8'h00);
      tick();
      tick();
      chk("rst_en", 32'(clk_en), 0);
      chk("rst_sq", 32'(clk_sq), 0);
      chk("rst_ready", 32'(cfg.cfg_ready), 0);
      chk("rst_err", 32'(cfg.cfg_err), 0);
      chk("rst_locked", 32'(locked), 0);
      // T1: ch0 at 0x40 pulses on edges 4,8,12 after release
      rst = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("t1_en0", 32'(clk_en[0]), 32'(k % 4 == 0));
         chk("t1_en1", 32'(clk_en[1]), 0);
         chk("t1_ready", 32'(cfg.cfg_ready), 1);
         chk("t1_locked", 32'(locked), 32'(k >= 4));
      end
      // T2: ch0 -> 0x80, applied on the wrap computed before edge 16
      drive(1'b1, 4'd0, 8'(inc_from_hz(100, 50, 8)));
      for (int k = 13; k <= 20; k++) begin
         tick();
         drive(1'b0, 4'd0, 8'h00);
         chk("t2_en0", 32'(clk_en[0]), 32'(k == 16 || k == 18 || k == 20));
         chk("t2_ready", 32'(cfg.cfg_ready), 32'(k >= 16));
         chk("t2_locked", 32'(locked), 32'(k == 20));
      end
      // T3: idle ch1 -> 0x20, applied next cycle, pulses every 8 from edge 30
      drive(1'b1, 4'd1, 8'h20);
      for (int k = 21; k <= 38; k++) begin
         tick();
         drive(1'b0, 4'd0, 8'h00);
         chk("t3_en0", 32'(clk_en[0]), 32'(k % 2 == 0));
         chk("t3_en1", 32'(clk_en[1]), 32'(k == 30 || k == 38));
         chk("t3_ready", 32'(cfg.cfg_ready), 32'(k != 21));
         chk("t3_locked", 32'(locked), 32'(k >= 26));
      end
      // T4: out-of-range channel
      drive(1'b1, 4'd5, 8'h11);
      for (int k = 39; k <= 46; k++) begin
         tick();
         drive(1'b0, 4'd0, 8'h00);
         chk("t4_err", 32'(cfg.cfg_err), 32'(k == 39));
         chk("t4_ready", 32'(cfg.cfg_ready), 1);
         chk("t4_locked", 32'(locked), 1);
         chk("t4_en0", 32'(clk_en[0]), 32'(k % 2 == 0));
         chk("t4_en1", 32'(clk_en[1]), 32'(k == 46));
      end
      // T5: slow ch0, a long pending write, a blocked second write, then reset
      drive(1'b1, 4'd0, 8'h01);
      tick();
      drive(1'b0, 4'd0, 8'h00);
      chk("t5_ready_a", 32'(cfg.cfg_ready), 0);
      tick();
      chk("t5_en0_a", 32'(clk_en[0]), 1);
      chk("t5_ready_b", 32'(cfg.cfg_ready), 1);
      drive(1'b1, 4'd0, 8'h40);
      tick();
      drive(1'b1, 4'd1, 8'h10);
      chk("t5_ready_c", 32'(cfg.cfg_ready), 0);
      for (int k = 50; k <= 55; k++) begin
         tick();
         chk("t5_hold_ready", 32'(cfg.cfg_ready), 0);
         chk("t5_hold_locked", 32'(locked), 0);
         chk("t5_hold_en0", 32'(clk_en[0]), 0);
         chk("t5_hold_en1", 32'(clk_en[1]), 32'(k == 54));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 8'h00);
      chk("t5_rst_ready", 32'(cfg.cfg_ready), 0);
      chk("t5_rst_en", 32'(clk_en), 0);
      chk("t5_rst_locked", 32'(locked), 0);
      for (int k = 57; k <= 64; k++) begin
         tick();
         chk("t5_ready", 32'(cfg.cfg_ready), 1);
         chk("t5_en0", 32'(clk_en[0]), 32'(k == 60 || k == 64));
         chk("t5_en1", 32'(clk_en[1]), 0);
         chk("t5_locked", 32'(locked), 32'(k >= 60));
      end
      // T6: square output at 0x40 has period 8, toggling on each ch0 pulse
      for (int k = 65; k <= 80; k++) begin
         tick();
         chk("t6_en0", 32'(clk_en[0]), 32'(k % 4 == 0));
         chk("t6_sq0", 32'(clk_sq[0]), SQ ? 32'((k / 4) % 2) : 0);
         chk("t6_sq1", 32'(clk_sq[1]), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
